// File: rtl/multi_cluster_token_router.sv
// Typed token dispatch from one token_engine to NUM_CL cluster FIFOs, plus round-robin PSUM return.
// Optional perf counters are built only when TOKEN_ROUTER_PERF_EN is defined.
module multi_cluster_token_router #(
  parameter int DATA_W     = 32,
  parameter int NUM_CL     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CL_W       = $clog2(NUM_CL)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NUM_CL-1:0]        cl_en_i,
  input  logic                     token_valid_i,
  output logic                     token_ready_o,
  input  logic [DATA_W-1:0]        token_data_i,
  input  logic [1:0]               token_type_i,
  input  logic [CL_W-1:0]          token_dest_i,
  input  logic                     token_bcast_i,
  output logic [NUM_CL*DATA_W-1:0] cl_data_o,
  output logic [NUM_CL-1:0]        cl_weight_valid_o,
  output logic [NUM_CL-1:0]        cl_ifmap_valid_o,
  output logic [NUM_CL-1:0]        cl_bias_valid_o,
  input  logic [NUM_CL-1:0]        cl_weight_ready_i,
  input  logic [NUM_CL-1:0]        cl_ifmap_ready_i,
  input  logic [NUM_CL-1:0]        cl_bias_ready_i,
  input  logic [NUM_CL-1:0]        cl_psum_valid_i,
  input  logic [NUM_CL*DATA_W-1:0] cl_psum_data_i,
  output logic [NUM_CL-1:0]        cl_psum_ready_o,
  output logic                     psum_valid_o,
  output logic [DATA_W-1:0]        psum_data_o,
  output logic [CL_W-1:0]          psum_src_o,
  input  logic                     psum_ready_i,
  output logic                     err_sticky_o
`ifdef TOKEN_ROUTER_PERF_EN
  ,
  output logic [31:0]              perf_tok_cnt_o,
  output logic [31:0]              perf_stall_cnt_o
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CL_W:0]    NUM_CL_V = (CL_W+1)'(NUM_CL);
  localparam logic [1:0] TYPE_WGT = 2'd0;
  localparam logic [1:0] TYPE_IFM = 2'd1;
  localparam logic [1:0] TYPE_BIA = 2'd2;
  localparam logic [1:0] TYPE_RSV = 2'd3;

  logic              dest_ok, legal, accept;
  logic [NUM_CL-1:0] tgt, full, push;

  assign dest_ok = ({1'b0, token_dest_i} < NUM_CL_V);
  assign legal   = (token_type_i != TYPE_RSV) && (token_bcast_i || dest_ok);

  always_comb begin
    tgt = '0;
    for (int i = 0; i < NUM_CL; i++)
      tgt[i] = token_bcast_i ? cl_en_i[i] : (dest_ok && (token_dest_i == CL_W'(i)));
  end

  // Illegal tokens are always accepted so a bad producer cannot wedge the link.
  assign token_ready_o = !legal || ((tgt & full) == '0);
  assign accept        = token_valid_i && token_ready_o;

  for (genvar g = 0; g < NUM_CL; g++) begin : g_cl
    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W+1:0] head;
    logic              nonempty, pop;

    assign head     = mem_q[rd_ptr_q];
    assign nonempty = (cnt_q != '0);
    assign full[g]  = (cnt_q == FULL_CNT);
    assign push[g]  = accept && legal && tgt[g] && !flush_i;

    assign cl_weight_valid_o[g] = nonempty && (head[DATA_W+1:DATA_W] == TYPE_WGT);
    assign cl_ifmap_valid_o[g]  = nonempty && (head[DATA_W+1:DATA_W] == TYPE_IFM);
    assign cl_bias_valid_o[g]   = nonempty && (head[DATA_W+1:DATA_W] == TYPE_BIA);
    assign cl_data_o[g*DATA_W +: DATA_W] = nonempty ? head[DATA_W-1:0] : '0;

    assign pop = !flush_i && ((cl_weight_valid_o[g] && cl_weight_ready_i[g]) ||
                              (cl_ifmap_valid_o[g]  && cl_ifmap_ready_i[g])  ||
                              (cl_bias_valid_o[g]   && cl_bias_ready_i[g]));

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (push[g]) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push[g] && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push[g] && pop) cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[g]) mem_q[wr_ptr_q] <= {token_type_i, token_data_i};
    end
  end

  logic              slot_valid_q, slot_valid_d;
  logic [DATA_W-1:0] slot_data_q, slot_data_d;
  logic [CL_W-1:0]   slot_src_q, slot_src_d;
  logic [CL_W-1:0]   rr_q, rr_d;
  logic              can_take, gnt_found;
  logic [CL_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_data;

  assign can_take = !slot_valid_q || psum_ready_i;

  // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_CL; i++) begin
      if (!gnt_found && cl_psum_valid_i[i] && (CL_W'(i) >= rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = CL_W'(i);
        gnt_data  = cl_psum_data_i[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_CL; i++) begin
      if (!gnt_found && cl_psum_valid_i[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = CL_W'(i);
        gnt_data  = cl_psum_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cl_psum_ready_o = '0;
    slot_valid_d    = slot_valid_q;
    slot_data_d     = slot_data_q;
    slot_src_d      = slot_src_q;
    rr_d            = rr_q;
    if (flush_i) begin
      slot_valid_d = 1'b0;
      slot_data_d  = '0;
      slot_src_d   = '0;
      rr_d         = '0;
    end else begin
      if (slot_valid_q && psum_ready_i) slot_valid_d = 1'b0;
      if (can_take && gnt_found) begin
        for (int i = 0; i < NUM_CL; i++)
          cl_psum_ready_o[i] = (gnt_idx == CL_W'(i));
        slot_valid_d = 1'b1;
        slot_data_d  = gnt_data;
        slot_src_d   = gnt_idx;
        rr_d         = (gnt_idx == CL_W'(NUM_CL-1)) ? '0 : gnt_idx + CL_W'(1);
      end
    end
  end

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (flush_i)                err_d = 1'b0;
    else if (accept && !legal)  err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_src_q   <= '0;
      rr_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_src_q   <= slot_src_d;
      rr_q         <= rr_d;
      err_q        <= err_d;
    end
  end

  assign psum_valid_o = slot_valid_q;
  assign psum_data_o  = slot_data_q;
  assign psum_src_o   = slot_src_q;
  assign err_sticky_o = err_q;

`ifdef TOKEN_ROUTER_PERF_EN
  logic [31:0] tok_cnt_q, tok_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    tok_cnt_d   = tok_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      tok_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (accept && legal && (tok_cnt_q != '1)) tok_cnt_d = tok_cnt_q + 32'd1;
      if (token_valid_i && !token_ready_o && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tok_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      tok_cnt_q   <= tok_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_tok_cnt_o   = tok_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cluster_token_router.sv
// Directed bench for multi_cluster_token_router: dispatch, back-pressure, drops, PSUM round-robin, reset.
module tb_multi_cluster_token_router;
  localparam int DW  = 32;
  localparam int NCL = 4;
  localparam int DEP = 4;
  localparam int CW  = 3;  // one spare bit so out-of-range destinations can be driven

  logic              clk = 1'b0;
  logic              rst_n, flush;
  logic [NCL-1:0]    cl_en;
  logic              token_valid, token_ready, token_bcast;
  logic [DW-1:0]     token_data;
  logic [1:0]        token_type;
  logic [CW-1:0]     token_dest;
  logic [NCL*DW-1:0] cl_data, cl_psum_data;
  logic [NCL-1:0]    w_valid, i_valid, b_valid, w_ready, i_ready, b_ready;
  logic [NCL-1:0]    cl_psum_valid, cl_psum_ready;
  logic              psum_valid, psum_ready, err_sticky;
  logic [DW-1:0]     psum_data;
  logic [CW-1:0]     psum_src;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multi_cluster_token_router #(.DATA_W(DW), .NUM_CL(NCL), .FIFO_DEPTH(DEP), .CL_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cl_en_i(cl_en),
    .token_valid_i(token_valid), .token_ready_o(token_ready), .token_data_i(token_data),
    .token_type_i(token_type), .token_dest_i(token_dest), .token_bcast_i(token_bcast),
    .cl_data_o(cl_data), .cl_weight_valid_o(w_valid), .cl_ifmap_valid_o(i_valid),
    .cl_bias_valid_o(b_valid), .cl_weight_ready_i(w_ready), .cl_ifmap_ready_i(i_ready),
    .cl_bias_ready_i(b_ready), .cl_psum_valid_i(cl_psum_valid), .cl_psum_data_i(cl_psum_data),
    .cl_psum_ready_o(cl_psum_ready), .psum_valid_o(psum_valid), .psum_data_o(psum_data),
    .psum_src_o(psum_src), .psum_ready_i(psum_ready), .err_sticky_o(err_sticky)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DW-1:0] cd(input int i);
    return cl_data[i*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; cl_en = '0;
    token_valid = 1'b0; token_data = '0; token_type = 2'd0; token_dest = '0; token_bcast = 1'b0;
    w_ready = '1; i_ready = '1; b_ready = '1;
    cl_psum_valid = '0; psum_ready = 1'b0;
    for (int i = 0; i < NCL; i++) cl_psum_data[i*DW +: DW] = 32'hD0 + i;
    tick(); tick();
    check("rst_valids", {w_valid, i_valid, b_valid}, 12'h000);
    check("rst_psum_valid", psum_valid, 1'b0);
    check("rst_err", err_sticky, 1'b0);
    rst_n = 1'b1;
    tick();

    // unicast weight to cluster 2
    token_valid = 1'b1; token_type = 2'd0; token_data = 32'hA5A5_0001; token_dest = 3'd2;
    settle();
    check("uni_ready", token_ready, 1'b1);
    tick();
    token_valid = 1'b0;
    settle();
    check("uni_wvalid", w_valid, 4'b0100);
    check("uni_data2", cd(2), 32'hA5A5_0001);
    check("uni_data0_idle", cd(0), 32'h0);
    check("uni_other_valids", {i_valid, b_valid}, 8'h00);
    tick();
    check("uni_popped", w_valid, 4'b0000);

    // broadcast against a full cluster-1 FIFO
    i_ready = '0;
    token_type = 2'd1; token_dest = 3'd1;
    for (int j = 0; j < DEP; j++) begin
      token_valid = 1'b1; token_data = 32'h100 + j;
      settle();
      check("fill1_ready", token_ready, 1'b1);
      tick();
    end
    token_bcast = 1'b1; cl_en = 4'b1011; token_data = 32'hB0;
    settle();
    check("bc_blocked", token_ready, 1'b0);
    tick();
    i_ready = 4'b0010;
    settle();
    check("bc_full_pop_ready", token_ready, 1'b0);
    check("bc_ivalid_c1", i_valid, 4'b0010);
    tick();
    i_ready = '0;
    settle();
    check("bc_unblocked", token_ready, 1'b1);
    tick();
    token_valid = 1'b0; token_bcast = 1'b0;
    settle();
    check("bc_ivalid", i_valid, 4'b1011);
    check("bc_data0", cd(0), 32'hB0);
    check("bc_data3", cd(3), 32'hB0);
    check("bc_data2_untouched", cd(2), 32'h0);
    i_ready = '1;
    for (int j = 0; j < 4; j++) begin
      check("c1_order", cd(1), (j < 3) ? 32'h101 + j : 32'hB0);
      tick();
      settle();
    end
    check("bc_drained", i_valid, 4'b0000);

    // bias back-pressure on cluster 0
    b_ready = '0; token_type = 2'd2; token_dest = 3'd0;
    for (int j = 0; j < DEP; j++) begin
      token_valid = 1'b1; token_data = 32'hC0 + j;
      settle();
      check("fill0_ready", token_ready, 1'b1);
      tick();
    end
    token_data = 32'hC4;
    settle();
    check("fifth_stall", token_ready, 1'b0);
    tick();
    b_ready = 4'b0001;
    settle();
    check("fifth_stall_pop", token_ready, 1'b0);
    check("bias_head0", cd(0), 32'hC0);
    tick();
    settle();
    check("fifth_ready", token_ready, 1'b1);
    check("bias_head1", cd(0), 32'hC1);
    tick();
    token_valid = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      settle();
      check("bias_order", cd(0), 32'hC0 + j);
      check("bias_valid", b_valid, 4'b0001);
      tick();
    end
    settle();
    check("bias_drained", b_valid, 4'b0000);

    // reserved type, out-of-range dest, empty broadcast
    token_valid = 1'b1; token_type = 2'd3; token_dest = 3'd0; token_data = 32'hEE;
    settle();
    check("rsv_ready", token_ready, 1'b1);
    tick();
    token_valid = 1'b0; token_type = 2'd0;
    settle();
    check("rsv_err", err_sticky, 1'b1);
    check("rsv_no_push", {w_valid, i_valid, b_valid}, 12'h000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_err", err_sticky, 1'b0);
    token_valid = 1'b1; token_dest = 3'd5;
    settle();
    check("dest5_ready", token_ready, 1'b1);
    tick();
    token_valid = 1'b0; token_dest = 3'd0;
    tick(); tick();
    check("dest5_err_sticky", err_sticky, 1'b1);
    check("dest5_no_push", {w_valid, i_valid, b_valid}, 12'h000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    token_valid = 1'b1; token_bcast = 1'b1; cl_en = 4'b0000; token_type = 2'd1;
    settle();
    check("bc_empty_ready", token_ready, 1'b1);
    tick();
    token_valid = 1'b0; token_bcast = 1'b0;
    settle();
    check("bc_empty_err", err_sticky, 1'b0);
    check("bc_empty_no_push", {w_valid, i_valid, b_valid}, 12'h000);

    // PSUM round-robin
    cl_psum_valid = 4'b1111; psum_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rr_grant", cl_psum_ready, 4'b0001 << (k % 4));
      tick();
      check("rr_valid", psum_valid, 1'b1);
      check("rr_src", psum_src, 3'(k % 4));
      check("rr_data", psum_data, 32'hD0 + (k % 4));
    end
    psum_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("hold_no_grant", cl_psum_ready, 4'b0000);
      tick();
      check("hold_src", psum_src, 3'd0);
      check("hold_data", psum_data, 32'hD0);
      check("hold_valid", psum_valid, 1'b1);
    end
    psum_ready = 1'b1;
    settle();
    check("drain_grant", cl_psum_ready, 4'b0010);
    tick();
    check("drain_src", psum_src, 3'd1);

    // asynchronous reset with tokens queued and a psum held
    cl_psum_valid = 4'b0001; psum_ready = 1'b0;
    w_ready = '0; token_type = 2'd0; token_dest = 3'd3;
    token_valid = 1'b1; token_data = 32'hE0;
    tick();
    token_data = 32'hE1;
    tick();
    token_valid = 1'b0; cl_psum_valid = '0;
    settle();
    check("pre_rst_wvalid", w_valid, 4'b1000);
    check("pre_rst_psum", psum_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_wvalid", w_valid, 4'b0000);
    check("rst_async_psum", psum_valid, 1'b0);
    check("rst_async_data3", cd(3), 32'h0);
    tick();
    w_ready = '1; psum_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_valids", {w_valid, i_valid, b_valid}, 12'h000);
      check("post_rst_psum", psum_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
